dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V core's load/store port: the memory end of the core's data-access handshake. It accepts one doubleword read or write request at a time, inserts a configurable number of wait states, commits the access to a local 64-bit array and returns a response with read data and an error flag. It replaces the core's inline data-memory array and sits between the core's MEM stage and storage.

## Interface
Parameters:
- DEPTH, 32: number of 64-bit doublewords; must be a power of two, at least 2.
- LATENCY, 1: wait states between request acceptance and access commit; range 0 to 15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; must be doubleword-aligned.
- req_wdata  in  64  store data.
- req_wstrb  in  8  byte enables for stores; bit i covers bits 8i+7:8i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  64  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready. On acceptance, the responder latches we, addr, wdata and wstrb, and loads the wait counter with LATENCY.
  - LATENCY=0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 1, go to RESP.
- Commit happens on the edge entering RESP, using the latched request:
  - Index = addr[3+log2(DEPTH)-1:3].
  - Error if addr[2:0]!=0 or addr[31:3] >= DEPTH.
  - On error: no array write, rdata=0, err=1.
  - Load: rdata = array[index].
  - Store: write the enabled bytes; rdata=0.
- RESP: rsp_valid=1, rsp_rdata and rsp_err stable. Leave to IDLE on rsp_valid && rsp_ready. If rsp_ready is held low, remain in RESP indefinitely.
- req_ready is 0 in WAIT and RESP. Input changes there are ignored, and only one transaction is outstanding.
- Array contents are not reset. Reads of never-written locations return X in simulation.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Acceptance edge to rsp_valid high: LATENCY+1 cycles.
- rsp_valid high to next req_ready: 1 cycle after the handshake edge. There is no same-cycle turnaround.
- Minimum period per transaction is LATENCY+2 cycles when rsp_ready is held high.
- Reset asserted in WAIT: the transaction is dropped and no write occurs.
- Reset asserted in RESP: the already-committed write persists and the response is dropped.
- req_valid held through RESP is not accepted until IDLE. The core must hold it, and it is accepted on the first IDLE cycle.
- Same address, store followed by load: the load returns the stored data, because each commit completes before the next acceptance.

## Configuration
- DMEM_BYTE_STROBE_EN defined: req_wstrb is honoured per byte. A store with wstrb=0 writes nothing but still responds.
- DMEM_BYTE_STROBE_EN undefined: every store writes all 8 bytes. req_wstrb remains a port but is ignored.

## Structure
- Shared package riscv_pkg holds:
  - WORDSIZE=32, DWORDSIZE=64, DMEMSIZE=32.
  - The dmem FSM state enum.
  - The error-condition helper function.
- One sub-module, dmem_array:
  - Synchronous-write, combinational-read 64-bit x DEPTH storage.
  - Write enable and 8-bit byte mask come from the FSM.
  - Keeps storage separable for later SRAM replacement.

## Test plan
- LATENCY=1. Store addr 0x10, wdata 0x1122334455667788, wstrb 0xFF, then load 0x10. Required: load rdata 0x1122334455667788, err=0, and rsp_valid 2 cycles after each acceptance.
- With DMEM_BYTE_STROBE_EN: store 0xAAAAAAAAAAAAAAAA to 0x08 with wstrb 0xFF, then store 0x00000000000000BB with wstrb 0x01, then load. Required: 0xAAAAAAAAAAAAAABB. Without the macro the same sequence returns 0x00000000000000BB.
- Load addr 0x0C (misaligned) and load addr 0x100 (index 32 ≥ DEPTH). Required: err=1 and rdata=0 for both. A subsequent load of 0x08 is unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_valid, rsp_rdata and rsp_err stay stable; req_ready=0 throughout; req_ready=1 one cycle after the handshake.
- LATENCY=0. Back-to-back loads with rsp_ready=1. Required: rsp_valid 1 cycle after acceptance and one transaction every 2 cycles.
- Assert rst during WAIT of a store to 0x18 holding 0x5555555555555555. Required: all outputs at reset values immediately, and a later load of 0x18 does not return 0x5555555555555555 (the old value is retained).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data widths, data-memory FSM states and
// the address error check used by the data-memory responder.
package riscv_pkg;

    localparam int WORDSIZE  = 32;
    localparam int DWORDSIZE = 64;
    localparam int DMEMSIZE  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Misaligned (not on a doubleword) or beyond the last doubleword of storage.
    function automatic logic dmem_addr_err(input logic [WORDSIZE-1:0] addr,
                                           input int unsigned          depth);
        logic [WORDSIZE-1:0] dword_idx;
        dword_idx = {3'b000, addr[WORDSIZE-1:3]};
        return (addr[2:0] != 3'b000) || (dword_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data-memory storage: 64-bit x DEPTH, synchronous byte-masked write,
// combinational read. Kept separate so it can be swapped for an SRAM macro.
module dmem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH = DMEMSIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [7:0]           wmask,
    input  logic [AW-1:0]        addr,
    input  logic [DWORDSIZE-1:0] wdata,
    output logic [DWORDSIZE-1:0] rdata
);

    logic [DWORDSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one doubleword access
// at a time with LATENCY wait states. Define DMEM_BYTE_STROBE_EN to honour req_wstrb.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | ready for a request; accepts on req_valid
//  WAIT  | wait-state down-counter running; commit when it hits 1
//  RESP  | committed response held until rsp_ready
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = DMEMSIZE,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WORDSIZE-1:0]  req_addr,
    input  logic [DWORDSIZE-1:0] req_wdata,
    input  logic [7:0]           req_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DWORDSIZE-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    dmem_state_e          state, state_nxt;
    logic [3:0]           cnt;
    logic                 accept, commit, live;

    logic                 lat_we;
    logic [WORDSIZE-1:0]  lat_addr;
    logic [DWORDSIZE-1:0] lat_wdata;

    logic                 c_we, c_err;
    logic [WORDSIZE-1:0]  c_addr;
    logic [DWORDSIZE-1:0] c_wdata;
    logic                 arr_we;
    logic [7:0]           arr_mask;
    logic [DWORDSIZE-1:0] arr_rdata;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live request is used instead of the (not yet loaded) latched copy.
    assign live    = (state == IDLE);
    assign c_we    = live ? req_we    : lat_we;
    assign c_addr  = live ? req_addr  : lat_addr;
    assign c_wdata = live ? req_wdata : lat_wdata;
    assign c_err   = dmem_addr_err(c_addr, DEPTH);
    assign arr_we  = commit && c_we && !c_err;

`ifdef DMEM_BYTE_STROBE_EN
    logic [7:0] lat_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wstrb <= '0;
        end else if (accept) begin
            lat_wstrb <= req_wstrb;
        end
    end

    assign arr_mask = live ? req_wstrb : lat_wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;
    assign arr_mask     = 8'hFF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= LAT;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (c_we || c_err) ? '0 : arr_rdata;
            rsp_err   <= c_err;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wmask (arr_mask),
        .addr  (c_addr[AW+2:3]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=0 (index 0) and one with
// LATENCY=1 (index 1), a transaction-level memory model and directed vectors.
module tb_dmem_responder;

    localparam int N_DW = 32;
`ifdef DMEM_BYTE_STROBE_EN
    localparam logic [63:0] EXP08 = 64'hAAAAAAAAAAAAAABB;
`else
    localparam logic [63:0] EXP08 = 64'h00000000000000BB;
`endif

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  req_valid, req_ready, req_we;
    logic [31:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wstrb [2];
    logic [1:0]  rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    dmem_responder #(.DEPTH(N_DW), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(N_DW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        $display("FAIL %s: no handshake within bound (cycle %0d)", nm, cyc);
    endtask

    function automatic int lat_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    // Transaction-level model: memory image plus the one outstanding access.
    logic [63:0] mmem [2][N_DW];
    bit          busy [2];
    int          due [2];
    logic [63:0] exp_rd [2];
    logic        exp_er [2];
    bit          pend_wr [2];
    int          pend_idx [2];
    logic [63:0] pend_data [2];
    logic [7:0]  pend_mask [2];
    bit          m_ev;
    logic [31:0] m_a;
    logic        m_er;
    int          m_idx;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                chk($sformatf("rst_req_ready%0d", k), 64'(req_ready[k]), 64'd1);
                chk($sformatf("rst_rsp_valid%0d", k), 64'(rsp_valid[k]), 64'd0);
                chk($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k], 64'd0);
                chk($sformatf("rst_rsp_err%0d", k), 64'(rsp_err[k]), 64'd0);
                busy[k]    = 1'b0;
                pend_wr[k] = 1'b0;
            end else begin
                m_ev = busy[k] && (cyc >= due[k]);
                chk($sformatf("req_ready%0d", k), 64'(req_ready[k]), 64'(!busy[k]));
                chk($sformatf("rsp_valid%0d", k), 64'(rsp_valid[k]), 64'(m_ev));
                if (m_ev) begin
                    if (pend_wr[k]) begin
                        for (int b = 0; b < 8; b++)
                            if (pend_mask[k][b])
                                mmem[k][pend_idx[k]][8*b +: 8] = pend_data[k][8*b +: 8];
                        pend_wr[k] = 1'b0;
                    end
                    chk($sformatf("rsp_rdata%0d", k), rsp_rdata[k], exp_rd[k]);
                    chk($sformatf("rsp_err%0d", k), 64'(rsp_err[k]), 64'(exp_er[k]));
                end
                if (!busy[k] && req_valid[k]) begin
                    m_a   = req_addr[k];
                    m_er  = (m_a % 8 != 0) || (m_a / 8 >= N_DW);
                    m_idx = int'((m_a / 8) % N_DW);
                    busy[k]      = 1'b1;
                    due[k]       = cyc + lat_of(k) + 1;
                    exp_er[k]    = m_er;
                    exp_rd[k]    = (m_er || req_we[k]) ? 64'd0 : mmem[k][m_idx];
                    pend_wr[k]   = req_we[k] && !m_er;
                    pend_idx[k]  = m_idx;
                    pend_data[k] = req_wdata[k];
`ifdef DMEM_BYTE_STROBE_EN
                    pend_mask[k] = req_wstrb[k];
`else
                    pend_mask[k] = 8'hFF;
`endif
                end else if (m_ev && rsp_ready[k]) begin
                    busy[k] = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [7:0] st,
                          output logic [63:0] rd, output logic er, output int lat);
        int acc;
        bit got;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_wstrb[k] = st;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1'b1;
        end
        if (!got) begin
            timeout_fail("accept");
            req_valid[k] = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[k]) got = 1'b1;
        end
        if (!got) begin
            timeout_fail("response");
            return;
        end
        lat = cyc - acc;
        rd  = rsp_rdata[k];
        er  = rsp_err[k];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          got;
        int          acc_q[$];

        rst       = 2'b11;
        req_valid = 2'b00;
        req_we    = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_wstrb[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 2'b00;

        // store then load, LATENCY=1
        do_req(1, 1'b1, 32'h10, 64'h1122334455667788, 8'hFF, rd, er, lat);
        chk("st10_lat", 64'(lat), 64'd2);
        chk("st10_rdata", rd, 64'd0);
        chk("st10_err", 64'(er), 64'd0);
        do_req(1, 1'b0, 32'h10, 64'd0, 8'h00, rd, er, lat);
        chk("ld10_lat", 64'(lat), 64'd2);
        chk("ld10_rdata", rd, 64'h1122334455667788);
        chk("ld10_err", 64'(er), 64'd0);

        // byte strobes
        do_req(1, 1'b1, 32'h08, 64'hAAAAAAAAAAAAAAAA, 8'hFF, rd, er, lat);
        do_req(1, 1'b1, 32'h08, 64'h00000000000000BB, 8'h01, rd, er, lat);
        do_req(1, 1'b0, 32'h08, 64'd0, 8'h00, rd, er, lat);
        chk("strobe_ld08", rd, EXP08);

        // error accesses leave storage untouched
        do_req(1, 1'b0, 32'h0C, 64'd0, 8'h00, rd, er, lat);
        chk("misalign_err", 64'(er), 64'd1);
        chk("misalign_rdata", rd, 64'd0);
        do_req(1, 1'b0, 32'h100, 64'd0, 8'h00, rd, er, lat);
        chk("range_err", 64'(er), 64'd1);
        chk("range_rdata", rd, 64'd0);
        do_req(1, 1'b1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, lat);
        chk("range_st_err", 64'(er), 64'd1);
        do_req(1, 1'b0, 32'h08, 64'd0, 8'h00, rd, er, lat);
        chk("after_err_ld08", rd, EXP08);
        chk("after_err_err", 64'(er), 64'd0);

        // back-pressure on the response, with a second request held pending
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h10;
        @(negedge clk);
        chk("hold_accept_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1 req_addr[1] = 32'h08;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) got = 1'b1;
        end
        if (!got) timeout_fail("hold_response");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid[1]), 64'd1);
            chk("hold_rdata", rsp_rdata[1], 64'h1122334455667788);
            chk("hold_err", 64'(rsp_err[1]), 64'd0);
            chk("hold_ready", 64'(req_ready[1]), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("hs_cycle_ready", 64'(req_ready[1]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) got = 1'b1;
        end
        if (!got) timeout_fail("held_req_response");
        chk("held_req_rdata", rsp_rdata[1], EXP08);
        @(posedge clk);
        #1;

        // reset during the wait state of a store
        do_req(1, 1'b1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h18;
        req_wdata[1] = 64'h5555555555555555;
        req_wstrb[1] = 8'hFF;
        @(negedge clk);
        chk("rstw_accept_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        chk("rstw_in_wait", 64'(req_ready[1]), 64'd0);
        rst[1] = 1'b1;
        #1;
        chk("rstw_req_ready", 64'(req_ready[1]), 64'd1);
        chk("rstw_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        chk("rstw_rsp_rdata", rsp_rdata[1], 64'd0);
        chk("rstw_rsp_err", 64'(rsp_err[1]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst[1] = 1'b0;
        do_req(1, 1'b0, 32'h18, 64'd0, 8'h00, rd, er, lat);
        chk("rstw_ld18", rd, 64'h0123456789ABCDEF);

        // LATENCY=0: single access then back-to-back loads
        do_req(0, 1'b1, 32'h10, 64'hCAFEF00DDEADBEEF, 8'hFF, rd, er, lat);
        chk("l0_st_lat", 64'(lat), 64'd1);
        do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, rd, er, lat);
        chk("l0_ld_lat", 64'(lat), 64'd1);
        chk("l0_ld_rdata", rd, 64'hCAFEF00DDEADBEEF);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc_q.push_back(cyc);
            if (rsp_valid[0]) chk("b2b_rdata", rsp_rdata[0], 64'hCAFEF00DDEADBEEF);
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", 64'(acc_q.size()), 64'd5);
        for (int i = 1; i < acc_q.size(); i++)
            chk("b2b_period", 64'(acc_q[i] - acc_q[i-1]), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
